// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes the RISC-V instruction format and immediate,
// and buffers results in a 2-entry FIFO behind a valid/ready handshake.
module imm_gen_pipe #(
   parameter int XLEN   = 32,
   parameter bit CSR_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
   localparam logic [2:0] FMT_Z = 3'd6;
   localparam logic [2:0] FMT_X = 3'd7;

   typedef logic [XLEN-1:0] xlen_t;

   typedef struct packed {
      logic [31:0] instr;
      xlen_t       pc;
      xlen_t       imm;
      logic [2:0]  fmt;
   } entry_t;

   logic [6:0]       opcode_s;
   logic [2:0]       funct3_s;
   logic [2:0]       dec_fmt_s;
   xlen_t            dec_imm_s;
   entry_t           dec_s;
   entry_t           head_r;
   entry_t           skid_r;
   logic [1:0]       count_r;
   logic [CNT_W-1:0] err_count_r;
   logic             push_s;
   logic             pop_s;

   assign opcode_s = in_instr[6:0];
   assign funct3_s = in_instr[14:12];

   // Format and immediate decode of the offered word; anything unrecognised is illegal with imm 0.
   always_comb begin
      dec_fmt_s = FMT_X;
      dec_imm_s = xlen_t'(1'b0);
      case (opcode_s)
         7'b0110011: begin
            dec_fmt_s = FMT_R;
         end
         7'b0111011: begin
            if (XLEN == 64) begin
               dec_fmt_s = FMT_R;
            end else begin
               dec_fmt_s = FMT_X;
            end
         end
         7'b0010011, 7'b0011011: begin
            if ((opcode_s == 7'b0011011) && (XLEN != 64)) begin
               dec_fmt_s = FMT_X;
            end else if (funct3_s[1:0] == 2'b01) begin
               // Shifts carry a zero-extended shamt; only RV64 OP-IMM uses the 6-bit form.
               if ((opcode_s == 7'b0010011) && (XLEN == 64)) begin
                  dec_fmt_s = FMT_I;
                  dec_imm_s = xlen_t'(in_instr[25:20]);
               end else if ((XLEN == 32) && in_instr[25]) begin
                  dec_fmt_s = FMT_X;
               end else begin
                  dec_fmt_s = FMT_I;
                  dec_imm_s = xlen_t'(in_instr[24:20]);
               end
            end else begin
               dec_fmt_s = FMT_I;
               dec_imm_s = xlen_t'($signed(in_instr[31:20]));
            end
         end
         7'b0000011, 7'b1100111, 7'b0001111: begin
            dec_fmt_s = FMT_I;
            dec_imm_s = xlen_t'($signed(in_instr[31:20]));
         end
         7'b0100011: begin
            dec_fmt_s = FMT_S;
            dec_imm_s = xlen_t'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         7'b1100011: begin
            dec_fmt_s = FMT_B;
            dec_imm_s = xlen_t'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt_s = FMT_U;
            dec_imm_s = xlen_t'($signed({in_instr[31:12], 12'd0}));
         end
         7'b1101111: begin
            dec_fmt_s = FMT_J;
            dec_imm_s = xlen_t'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
         end
         7'b1110011: begin
            case (funct3_s)
               3'b000: begin
                  dec_fmt_s = FMT_I;
                  dec_imm_s = xlen_t'($signed(in_instr[31:20]));
               end
               3'b001, 3'b010, 3'b011: begin
                  if (CSR_EN) begin
                     dec_fmt_s = FMT_I;
                     dec_imm_s = xlen_t'(in_instr[31:20]);
                  end else begin
                     dec_fmt_s = FMT_X;
                  end
               end
               3'b101, 3'b110, 3'b111: begin
                  if (CSR_EN) begin
                     dec_fmt_s = FMT_Z;
                     dec_imm_s = xlen_t'(in_instr[19:15]);
                  end else begin
                     dec_fmt_s = FMT_X;
                  end
               end
               default: begin
                  dec_fmt_s = FMT_X;
               end
            endcase
         end
         default: begin
            dec_fmt_s = FMT_X;
         end
      endcase
   end

   assign dec_s    = '{instr: in_instr, pc: in_pc, imm: dec_imm_s, fmt: dec_fmt_s};
   assign in_ready = (count_r != 2'd2) && !flush;
   assign push_s   = in_valid && in_ready;
   assign pop_s    = out_valid && out_ready;

   // Two-entry FIFO: head_r is the presented (oldest) entry, skid_r the second; head holds when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r      <= '0;
         skid_r      <= '0;
         count_r     <= 2'd0;
         err_count_r <= '0;
      end else if (flush) begin
         count_r <= 2'd0;
      end else begin
         if (pop_s && out_illegal && (err_count_r != {CNT_W{1'b1}})) begin
            err_count_r <= err_count_r + CNT_W'(1);
         end
         case (count_r)
            2'd0: begin
               if (push_s) begin
                  head_r  <= dec_s;
                  count_r <= 2'd1;
               end
            end
            2'd1: begin
               if (push_s && pop_s) begin
                  head_r <= dec_s;
               end else if (push_s) begin
                  skid_r  <= dec_s;
                  count_r <= 2'd2;
               end else if (pop_s) begin
                  count_r <= 2'd0;
               end
            end
            2'd2: begin
               if (pop_s) begin
                  head_r  <= skid_r;
                  count_r <= 2'd1;
               end
            end
            default: begin
               count_r <= 2'd0;
            end
         endcase
      end
   end

   assign out_valid   = (count_r != 2'd0);
   assign out_instr   = head_r.instr;
   assign out_pc      = head_r.pc;
   assign out_imm     = head_r.imm;
   assign out_fmt     = head_r.fmt;
   assign out_illegal = (head_r.fmt == FMT_X);
   assign err_count   = err_count_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV32/CSR instance and an RV64/no-CSR instance
// share stimulus; each has its own queue of expected entries.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [31:0] a_out_instr, a_out_pc, a_out_imm;
   logic [2:0]  a_out_fmt;
   logic [15:0] a_err_count;

   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [31:0] b_out_instr;
   logic [63:0] b_out_pc, b_out_imm;
   logic [2:0]  b_out_fmt;
   logic [3:0]  b_err_count;

   imm_gen_pipe #(.XLEN(32), .CSR_EN(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_instr(a_out_instr), .out_pc(a_out_pc), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
      .out_illegal(a_out_illegal), .err_count(a_err_count));

   imm_gen_pipe #(.XLEN(64), .CSR_EN(1'b0), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_pc({32'd0, in_pc}), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_instr(b_out_instr), .out_pc(b_out_pc), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
      .out_illegal(b_out_illegal), .err_count(b_err_count));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [2:0]  fmt;
      int          cyc;
   } exp_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] ia;
      logic [2:0]  fa;
      logic [63:0] ib;
      logic [2:0]  fb;
   } vec_t;

   vec_t tbl [15] = '{
      '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1},
      '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2},
      '{32'hFE208CE3, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3},
      '{32'h001000EF, 32'h00000800, 3'd5, 64'h0000000000000800, 3'd5},
      '{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4},
      '{32'h03F09093, 32'h00000000, 3'd7, 64'h000000000000003F, 3'd1},
      '{32'h300FD073, 32'h0000001F, 3'd6, 64'h0000000000000000, 3'd7},
      '{32'h002081B3, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0},
      '{32'hFFF0809B, 32'h00000000, 3'd7, 64'hFFFFFFFFFFFFFFFF, 3'd1},
      '{32'h00000073, 32'h00000000, 3'd1, 64'h0000000000000000, 3'd1},
      '{32'h30009073, 32'h00000300, 3'd1, 64'h0000000000000000, 3'd7},
      '{32'h00000000, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7},
      '{32'h00004073, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7},
      '{32'h4030D093, 32'h00000003, 3'd1, 64'h0000000000000003, 3'd1},
      '{32'h12345097, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4}
   };

   exp_t        qa[$], qb[$];
   logic [31:0] cur_ia, pc_next;
   logic [63:0] cur_ib;
   logic [2:0]  cur_fa, cur_fb;
   int          n_chk = 0, n_fail = 0, cyc = 0;
   int          err_a = 0, err_b = 0;
   bit          lat_chk = 1'b1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst_n && !flush) begin
         if (a_out_valid && out_ready) begin
            chk("a_qnonempty", qa.size() != 0, 1);
            if (qa.size() != 0) begin
               e = qa.pop_front();
               chk("a_instr", a_out_instr, e.instr);
               chk("a_pc", a_out_pc, e.pc);
               chk("a_imm", a_out_imm, e.imm);
               chk("a_fmt", a_out_fmt, e.fmt);
               chk("a_ill", a_out_illegal, e.fmt == 3'd7);
               if (lat_chk) chk("a_lat", cyc - e.cyc, 1);
               if (e.fmt == 3'd7 && err_a != 65535) err_a++;
            end
         end
         if (b_out_valid && out_ready) begin
            chk("b_qnonempty", qb.size() != 0, 1);
            if (qb.size() != 0) begin
               e = qb.pop_front();
               chk("b_instr", b_out_instr, e.instr);
               chk("b_pc", b_out_pc, e.pc);
               chk("b_imm", b_out_imm, e.imm);
               chk("b_fmt", b_out_fmt, e.fmt);
               chk("b_ill", b_out_illegal, e.fmt == 3'd7);
               if (e.fmt == 3'd7 && err_b != 15) err_b++;
            end
         end
         if (in_valid && a_in_ready) begin
            qa.push_back('{in_instr, {32'd0, in_pc}, {32'd0, cur_ia}, cur_fa, cyc});
            qb.push_back('{in_instr, {32'd0, in_pc}, cur_ib, cur_fb, cyc});
         end
      end
   end

   task automatic offer(input logic [31:0] instr, input logic [31:0] ia, input logic [2:0] fa,
                        input logic [63:0] ib, input logic [2:0] fb);
      in_instr = instr; in_pc = pc_next;
      cur_ia = ia; cur_fa = fa; cur_ib = ib; cur_fb = fb;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept();
      bit hs = 1'b0;
      int n = 0;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = a_in_ready;
         @(posedge clk); #1;
         n++;
      end
      chk("accept", hs, 1);
      in_valid = 1'b0;
      pc_next = pc_next + 32'd4;
   endtask

   task automatic send(input vec_t v);
      offer(v.instr, v.ia, v.fa, v.ib, v.fb);
      wait_accept();
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
      chk("a_drained", qa.size(), 0);
      chk("b_drained", qb.size(), 0);
   endtask

   initial begin
      vec_t ill;
      ill = '{32'h00000000, 32'd0, 3'd7, 64'd0, 3'd7};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = 32'd0; in_pc = 32'd0; pc_next = 32'h1000;
      #12;
      chk("rst_valid", a_out_valid, 0);
      chk("rst_imm", a_out_imm, 0);
      chk("rst_err", a_err_count, 0);
      chk("rst_ready", a_in_ready, 1);
      chk("rst_b_fmt", b_out_fmt, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Full-rate stream through both decoders
      foreach (tbl[i]) send(tbl[i]);
      drain();
      chk("a_err_stream", a_err_count, 4);
      chk("b_err_stream", b_err_count, 4);

      // Back-pressure: two accepts then stall with stable output
      lat_chk = 1'b0; out_ready = 1'b0;
      send('{32'h00500093, 32'd5, 3'd1, 64'd5, 3'd1});
      send(tbl[1]);
      offer(tbl[4].instr, tbl[4].ia, tbl[4].fa, tbl[4].ib, tbl[4].fb);
      repeat (3) begin
         @(negedge clk);
         chk("bp_ready", a_in_ready, 0);
         chk("bp_valid", a_out_valid, 1);
         chk("bp_hold", a_out_instr, 32'h00500093);
         chk("bp_hold_imm", b_out_imm, 64'd5);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_accept();
      drain();

      // Flush with two illegal entries queued and a pop offered in the flush cycle
      out_ready = 1'b0;
      send(ill);
      send(ill);
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000093;
      @(negedge clk);
      chk("flush_ready", a_in_ready, 0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      qa.delete(); qb.delete();
      chk("flush_valid", a_out_valid, 0);
      chk("flush_b_valid", b_out_valid, 0);
      chk("flush_err", a_err_count, err_a);
      chk("flush_err_b", b_err_count, err_b);
      send(tbl[0]);
      drain();

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(tbl[2]);
      send(tbl[6]);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", a_out_valid, 0);
      chk("arst_instr", a_out_instr, 0);
      chk("arst_pc", a_out_pc, 0);
      chk("arst_imm", b_out_imm, 0);
      chk("arst_fmt", a_out_fmt, 0);
      chk("arst_ill", b_out_illegal, 0);
      chk("arst_err", a_err_count, 0);
      qa.delete(); qb.delete(); err_a = 0; err_b = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Error counter: wide counter counts, narrow one saturates
      out_ready = 1'b1; lat_chk = 1'b1;
      repeat (20) send(ill);
      drain();
      chk("sat_a", a_err_count, 20);
      chk("sat_b", b_err_count, 15);
      chk("sat_b_model", b_err_count, err_b);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator in the decode path.
- Accepts instruction words over a valid/ready handshake and decodes the instruction format.
- Produces an XLEN-wide immediate, with shift-amount and CSR-immediate handling and illegal-opcode detection.
- Buffers results in a 2-entry FIFO so decode sustains full throughput under back-pressure; sits between fetch and the scoreboard issue stage.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CSR_EN, 1, 1 = decode SYSTEM CSR forms; 0 = only ECALL/EBREAK legal, all other SYSTEM forms illegal.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address, passed through.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_instr  out  32  instruction, passed through.
- out_pc  out  XLEN  PC, passed through.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm), 7 illegal.
- out_illegal  out  1  equals (out_fmt==7).
- err_count  out  CNT_W  saturating count of illegal entries delivered.

Behaviour:
- Reset (rst_n low, async): FIFO empty; out_valid=0; out_instr/out_pc/out_imm=0; out_fmt=0; out_illegal=0; err_count=0.
- Decode is combinational on in_instr; the result is written into the FIFO on input handshake (in_valid && in_ready).
- in_instr[1:0]!=2'b11 → illegal.
- R: opcode 0110011. Also 0111011 when XLEN=64, otherwise illegal. imm=0.
- I: opcodes 0010011, 0000011, 1100111, 0001111. Also 0011011 when XLEN=64, otherwise illegal. imm = sign-extend(instr[31:20]) to XLEN.
- Shift override, opcode 0010011/0011011 with funct3 001 or 101:
  - imm = zero-extended shamt.
  - Shamt is instr[25:20] for XLEN=64 on 0010011, otherwise instr[24:20].
  - XLEN=32 with instr[25]=1 → illegal.
- S (0100011): sign-extend {instr[31:25], instr[11:7]}.
- B (1100011): sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U (0110111, 0010111): {instr[31:12], 12'b0}, sign-extended to XLEN when XLEN=64.
- J (1101111): sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- SYSTEM (1110011):
  - funct3=000 → fmt I, imm = sign-extend(instr[31:20]).
  - CSR_EN=1, funct3 in {001,010,011} → fmt I, imm = zero-extend(instr[31:20]) (CSR address).
  - CSR_EN=1, funct3 in {101,110,111} → fmt Z, imm = zero-extend(instr[19:15]).
  - funct3=100, or CSR_EN=0 with funct3!=000 → illegal.
- Any other opcode → illegal. Illegal entries carry imm=0, fmt=7; instr and pc still pass through.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one word per cycle while out_ready=1.
- FIFO: 2 entries; output is always the oldest entry.
  - in_ready = (count<2) && !flush, combinational from registered count.
  - Simultaneous push and pop: allowed at count 1 and 2-1 states; count unchanged and order preserved.
  - Full (count=2): in_ready=0 until a pop.
  - Empty: out_valid=0; output data holds its last value, with no new entry bypassed in the same cycle.
- Output stability: while out_valid && !out_ready, all out_* hold unchanged.
- Flush: at the next edge count→0 and out_valid=0. Input offered in the flush cycle is dropped. Any pop in that cycle is ignored by err_count. err_count is not cleared.
- err_count increments by 1 on each output handshake where out_illegal=1. It saturates at all-ones, with no wrap.
- Reset mid-operation: all entries discarded immediately; no partial output.

Test Plan:
- Stream addi x1,x0,-1 (0xFFF00093), sw, beq, jal, lui with out_ready=1 → each appears one cycle later; imm 0xFFFFFFFF, then S/B/J/U values per the formulas; fmt 1,2,3,5,4 respectively.
- Hold out_ready=0, push 3 words → in_ready drops after 2 accepts; third word held by the source; out_* stable. Release → words delivered in order, no loss or duplication.
- XLEN=64: slli x1,x1,63 (0x03F09093) → imm=63, fmt=1. XLEN=32: same word → fmt=7, imm=0, err_count=1.
- CSR_EN=1: csrrwi x0,0x300,31 (0x300FD073) → fmt=6, imm=31. CSR_EN=0: same word → illegal.
- Feed 0x00000000 (instr[1:0]=00) 65537 times with CNT_W=16 → err_count saturates at 0xFFFF.
- With 2 entries queued, assert flush → out_valid=0 next cycle, err_count unchanged. Assert rst_n low mid-stream → all outputs return to reset values asynchronously.
